// File: rtl/vga_sink_pkg.sv
// rtl/vga_sink_pkg.sv - shared types, screen geometry and address helper for the plot sink
package vga_sink_pkg;

    localparam logic [7:0] SCREEN_W = 8'd160;
    localparam logic [6:0] SCREEN_H = 7'd120;
    localparam int         FB_DEPTH = 19200;
    localparam int         FB_AW    = 15;
    localparam logic [FB_AW-1:0] FB_LAST = 15'(FB_DEPTH - 1);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_t;

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    // y*160 + x without a multiplier
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous FIFO of plot requests with a registered occupancy count
module plot_fifo
    import vga_sink_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  plot_t                  din,
    input  logic                   pop,
    output plot_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    plot_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vga_plot_sink.sv
// rtl/vga_plot_sink.sv - plot stream sink: FIFO, range check, fill FSM and scan-priority RAM port
module vga_plot_sink
    import vga_sink_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [2:0]       vga_colour,
    input  logic             vga_plot,
    output logic             plot_ready,
    input  logic             scan_req,
    input  logic [7:0]       scan_x,
    input  logic [6:0]       scan_y,
    output logic             scan_valid,
    output logic [2:0]       scan_colour,
    input  logic             fill_start,
    input  logic [2:0]       fill_colour,
    output logic             fill_done,
    output logic             busy,
    output logic             overflow,
    output logic [15:0]      drop_count,
    output logic [FB_AW-1:0] mem_addr,
    output logic [2:0]       mem_wdata,
    output logic             mem_we,
    input  logic [2:0]       mem_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fill_state_t      state_q, state_d;
    logic [FB_AW-1:0] fill_addr_q, fill_addr_d;
    logic [2:0]       fill_colour_q, fill_colour_d;
    plot_t            plot_in, head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic             scan_hit, scan_hit_q;
    logic             plot_ok, plot_accept, plot_push;

    assign plot_in     = '{x: vga_x, y: vga_y, colour: vga_colour};
    assign plot_ready  = !fifo_full;
    assign plot_ok     = on_screen(vga_x, vga_y);
    assign plot_accept = vga_plot && plot_ready;
    assign plot_push   = plot_accept && plot_ok;
    assign scan_hit    = scan_req && on_screen(scan_x, scan_y);

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (plot_push),
        .din   (plot_in),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Port arbitration (scan > fill > drain) and fill sequencing share one decision
    always_comb begin
        state_d       = state_q;
        fill_addr_d   = fill_addr_q;
        fill_colour_d = fill_colour_q;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        fifo_pop      = 1'b0;

        if (scan_hit) begin
            mem_addr = fb_addr(scan_x, scan_y);
        end else if (state_q == FILL) begin
            mem_addr  = fill_addr_q;
            mem_wdata = fill_colour_q;
            mem_we    = 1'b1;
        end else if (state_q == IDLE && !fifo_empty) begin
            fifo_pop  = 1'b1;
            mem_addr  = fb_addr(head.x, head.y);
            mem_wdata = head.colour;
            mem_we    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d       = FILL;
                    fill_addr_d   = '0;
                    fill_colour_d = fill_colour;
                end
            end
            FILL: begin
                if (!scan_hit) begin
                    if (fill_addr_q == FB_LAST) state_d = DONE;
                    else                        fill_addr_d = fill_addr_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign fill_done   = (state_q == DONE);
    assign busy        = (fifo_count != '0) || (state_q != IDLE);
    assign scan_colour = scan_hit_q ? mem_rdata : 3'b000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fill_addr_q   <= '0;
            fill_colour_q <= '0;
            scan_valid    <= 1'b0;
            scan_hit_q    <= 1'b0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_colour_q <= fill_colour_d;
            scan_valid    <= scan_req;
            scan_hit_q    <= scan_hit;
            if (vga_plot && !plot_ready) overflow <= 1'b1;
            if (plot_accept && !plot_ok && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
        end
    end

endmodule
